// File: rtl/map_access_arbiter.sv
// Round-robin arbiter sharing one map instance between NUM_REQ requesters.
// One transaction in flight; LOOKUP result waits are bounded by a timeout.
module map_access_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned KEY_WIDTH      = 8,
    parameter int unsigned VALUE_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [VALUE_WIDTH-1:0]         rsp_value,
    output logic                           rsp_timeout,
    output logic [1:0]                     map_op,
    output logic [KEY_WIDTH-1:0]           map_key,
    output logic [VALUE_WIDTH-1:0]         map_value,
    output logic                           map_valid,
    input  logic                           map_ready,
    input  logic [VALUE_WIDTH-1:0]         map_rsp_value,
    input  logic                           map_rsp_valid,
    output logic                           map_rsp_ready,
    output logic [7:0]                     drop_cnt
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OpNop    = 2'b00;
    localparam logic [1:0] OpLookup = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [1:0]             op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [7:0]             drop_q, drop_d;

    logic [1:0]             op_arr    [NUM_REQ];
    logic [KEY_WIDTH-1:0]   key_arr   [NUM_REQ];
    logic [VALUE_WIDTH-1:0] value_arr [NUM_REQ];

    logic                   found;
    logic [GW-1:0]          winner;
    int unsigned            scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i]    = req_op[2*i +: 2];
            key_arr[i]   = req_key[KEY_WIDTH*i +: KEY_WIDTH];
            value_arr[i] = req_value[VALUE_WIDTH*i +: VALUE_WIDTH];
        end
    end

    // Scan starts just after the last granted requester and wraps around.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[GW'(scan_idx)]) begin
                found  = 1'b1;
                winner = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        op_d          = op_q;
        key_d         = key_q;
        value_d       = value_q;
        timer_d       = timer_q;
        rsp_value_d   = rsp_value_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready     = '0;
        rsp_valid     = '0;
        map_valid     = 1'b0;
        map_rsp_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                map_rsp_ready = 1'b1;
                if (found) begin
                    req_ready[winner] = 1'b1;
                    grant_d           = winner;
                    op_d              = op_arr[winner];
                    key_d             = key_arr[winner];
                    value_d           = value_arr[winner];
                    rsp_value_d       = '0;
                    rsp_timeout_d     = 1'b0;
                    state_d           = (op_arr[winner] == OpNop) ? StResp : StIssue;
                end
            end
            StIssue: begin
                map_valid     = 1'b1;
                map_rsp_ready = 1'b1;
                if (map_ready) begin
                    if (op_q == OpLookup) begin
                        state_d = StWait;
                        timer_d = '0;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                map_rsp_ready = 1'b1;
                timer_d       = timer_q + 1'b1;
                // A response arriving on the final timer cycle still wins.
                if (map_rsp_valid) begin
                    rsp_value_d   = map_rsp_value;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_value_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Combinational outputs must read zero while reset is held.
        if (!reset_n) begin
            req_ready     = '0;
            map_rsp_ready = 1'b0;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (map_rsp_valid && map_rsp_ready && (state_q != StWait) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_grant_q  <= GW'(NUM_REQ - 1);
            op_q          <= '0;
            key_q         <= '0;
            value_q       <= '0;
            timer_q       <= '0;
            rsp_value_q   <= '0;
            rsp_timeout_q <= 1'b0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            op_q          <= op_d;
            key_q         <= key_d;
            value_q       <= value_d;
            timer_q       <= timer_d;
            rsp_value_q   <= rsp_value_d;
            rsp_timeout_q <= rsp_timeout_d;
            drop_q        <= drop_d;
        end
    end

    assign map_op      = (state_q == StIssue) ? op_q : '0;
    assign map_key     = (state_q == StIssue) ? key_q : '0;
    assign map_value   = (state_q == StIssue) ? value_q : '0;
    assign rsp_value   = (state_q == StResp) ? rsp_value_q : '0;
    assign rsp_timeout = (state_q == StResp) ? rsp_timeout_q : 1'b0;
    assign drop_cnt    = drop_q;

endmodule
